// File: rtl/exec_unit.sv
// exec_unit: register file, single-cycle ALU and optional iterative RV32M engine behind one issue port
// Ports: clk, nrst (async active-low reset); in_valid/in_ready issue handshake carrying rs1, rs2, rd,
//        op, is_md, md_op; wb_valid/wb_rd/wb_data/illegal one-cycle writeback pulse;
//        dbg_rsel/dbg_rdata raw combinational register read.
// Build option: define EXEC_MD_EN to include the multiply/divide engine; without it md ops retire as illegal.
package rv32ima_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_NOR
    } aluop_t;
endpackage

module exec_unit
    import rv32ima_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int RIDX_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RIDX_W-1:0] rs1,
    input  logic [RIDX_W-1:0] rs2,
    input  logic [RIDX_W-1:0] rd,
    input  aluop_t            op,
    input  logic              is_md,
    input  logic [2:0]        md_op,
    output logic              wb_valid,
    output logic [RIDX_W-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              illegal,
    input  logic [RIDX_W-1:0] dbg_rsel,
    output logic [XLEN-1:0]   dbg_rdata
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, MD_BUSY, WB} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   rf_q [NREGS];
    logic [RIDX_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              illegal_q, illegal_d;
    logic              accept, fwd_ok;
    logic [XLEN-1:0]   opa, opb, alu_res;
    logic [SW-1:0]     shamt;

    assign in_ready  = state_q != MD_BUSY;
    assign accept    = in_valid && in_ready;
    assign wb_valid  = state_q == WB;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign illegal   = wb_valid && illegal_q;
    assign dbg_rdata = rf_q[dbg_rsel];

    // A result in WB is written only at the end of the cycle, so an op accepted now must bypass it.
    assign fwd_ok = wb_valid && !illegal_q && wb_rd_q != '0;
    assign opa    = fwd_ok && rs1 == wb_rd_q ? wb_data_q : rf_q[rs1];
    assign opb    = fwd_ok && rs2 == wb_rd_q ? wb_data_q : rf_q[rs2];
    assign shamt  = opb[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            ALU_ADD:  alu_res = opa + opb;
            ALU_SUB:  alu_res = opa - opb;
            ALU_SLL:  alu_res = opa << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, opa < opb};
            ALU_XOR:  alu_res = opa ^ opb;
            ALU_SRL:  alu_res = opa >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
            ALU_OR:   alu_res = opa | opb;
            ALU_AND:  alu_res = opa & opb;
            ALU_NOR:  alu_res = ~(opa | opb);
            default:  alu_res = '0;
        endcase
    end

`ifdef EXEC_MD_EN
    localparam int CW = $clog2(XLEN + 1);

    // prod_q upper half: multiply accumulator / divide remainder; lower half: multiplier / dividend->quotient.
    logic [2*XLEN-1:0] prod_q, prod_d, step, full;
    logic [XLEN-1:0]   mdb_q, mdb_d, mag_a, mag_b, div_sel, md_res, special;
    logic [XLEN:0]     mul_sum, trial;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        mdop_q, mdop_d;
    logic              neg_q, neg_d, sa, sb, a_neg, b_neg, div0, ovf;

    // The engine works on magnitudes; the sign is reapplied on the final step.
    assign sa      = md_op[2] ? !md_op[0] : (md_op == 3'd1 || md_op == 3'd2);
    assign sb      = md_op[2] ? !md_op[0] : md_op == 3'd1;
    assign a_neg   = sa && opa[XLEN-1];
    assign b_neg   = sb && opb[XLEN-1];
    assign mag_a   = a_neg ? -opa : opa;
    assign mag_b   = b_neg ? -opb : opb;
    assign div0    = md_op[2] && opb == '0;
    assign ovf     = md_op[2] && !md_op[0] && opa == {1'b1, {(XLEN-1){1'b0}}} && opb == '1;
    assign special = div0 ? (md_op[1] ? opa : '1) : (md_op[1] ? '0 : opa);
    assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mdb_q} : '0);
    assign trial   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]} - {1'b0, mdb_q};
    assign step    = !mdop_q[2] ? {mul_sum, prod_q[XLEN-1:1]} :
                     trial[XLEN] ? {prod_q[2*XLEN-2:0], 1'b0} :
                     {trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    assign full    = neg_q ? -step : step;
    assign div_sel = mdop_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    assign md_res  = mdop_q[2] ? (neg_q ? -div_sel : div_sel) :
                     mdop_q[1:0] == 2'd0 ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prod_q <= '0;
            mdb_q  <= '0;
            cnt_q  <= '0;
            mdop_q <= '0;
            neg_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            mdb_q  <= mdb_d;
            cnt_q  <= cnt_d;
            mdop_q <= mdop_d;
            neg_q  <= neg_d;
        end
    end
`else
    logic unused_md;
    assign unused_md = ^md_op;
`endif

    always_comb begin
        state_d   = state_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        illegal_d = illegal_q;
`ifdef EXEC_MD_EN
        prod_d = prod_q;
        mdb_d  = mdb_q;
        cnt_d  = cnt_q;
        mdop_d = mdop_q;
        neg_d  = neg_q;
        if (state_q == MD_BUSY) begin
            prod_d = step;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d   = WB;
                wb_data_d = md_res;
            end
        end
`endif
        if (state_q == WB)
            state_d = IDLE;
        if (accept) begin
            wb_rd_d   = rd;
            illegal_d = 1'b0;
            state_d   = WB;
            wb_data_d = alu_res;
            if (is_md) begin
`ifdef EXEC_MD_EN
                if (div0 || ovf)
                    wb_data_d = special;
                else begin
                    state_d = MD_BUSY;
                    prod_d  = {{XLEN{1'b0}}, mag_a};
                    mdb_d   = mag_b;
                    cnt_d   = CW'(XLEN);
                    mdop_d  = md_op;
                    neg_d   = md_op[2] && md_op[1] ? a_neg : a_neg ^ b_neg;
                end
`else
                wb_data_d = '0;
                illegal_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            illegal_q <= illegal_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NREGS; i++)
                rf_q[i] <= '0;
        end else if (wb_valid && !illegal_q && wb_rd_q != '0) begin
            rf_q[wb_rd_q] <= wb_data_q;
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: scoreboard bench for exec_unit covering reset, abort, ALU, forwarding, x0 and md/illegal ops
module tb_exec_unit;
    import rv32ima_pkg::*;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int RW = 5;

    typedef struct packed {
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            ill;
    } exp_t;

    logic            clk = 1'b0, nrst = 1'b0, in_valid = 1'b0, is_md = 1'b0;
    logic            in_ready, wb_valid, illegal;
    logic [RW-1:0]   rs1 = '0, rs2 = '0, rd = '0, dbg_rsel = '0, wb_rd;
    aluop_t          op = ALU_ADD;
    logic [2:0]      md_op = '0;
    logic [XLEN-1:0] wb_data, dbg_rdata;

    exp_t exp_q[$];
    exp_t e;
    int   wb_cyc_q[$];
    int   checks = 0, passed = 0, cyc = 0, last_acc = 0;

    exec_unit #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .op(op), .is_md(is_md), .md_op(md_op),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal),
        .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every writeback must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (nrst && wb_valid) begin
            checks++;
            wb_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                $display("FAIL wb_unexpected: got rd=%0d data=%h ill=%b, required no writeback", wb_rd, wb_data, illegal);
            end else begin
                e = exp_q.pop_front();
                if ({wb_rd, wb_data, illegal} !== e)
                    $display("FAIL wb_result: got rd=%0d data=%h ill=%b, required rd=%0d data=%h ill=%b",
                             wb_rd, wb_data, illegal, e.rd, e.data, e.ill);
                else
                    passed++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input int s1, input int s2, input int d, input aluop_t o, input bit m,
                         input int f, input logic [XLEN-1:0] ed, input bit ei);
        int n = 0;
        @(negedge clk);
        rs1 = RW'(s1); rs2 = RW'(s2); rd = RW'(d); op = o; is_md = m; md_op = 3'(f);
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        exp_q.push_back(exp_t'({RW'(d), ed, ei}));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || wb_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, wb_valid, wb_rd, wb_data, illegal} !== {1'b1, 1'b0, 5'd0, 32'd0, 1'b0})
            $display("FAIL reset_outputs: got rdy=%b v=%b rd=%0d data=%h ill=%b, required 1 0 0 0 0",
                     in_ready, wb_valid, wb_rd, wb_data, illegal);
        else
            passed++;
        for (int i = 0; i < NREGS; i++) begin
            dbg_rsel = RW'(i);
            #1;
            checks++;
            if (dbg_rdata !== 32'd0)
                $display("FAIL reset_reg x%0d: got %h, required 0", i, dbg_rdata);
            else
                passed++;
        end
    endtask

    task automatic test_abort();
        issue(0, 0, 9, ALU_NOR, 1'b0, 0, 32'hFFFF_FFFF, 1'b0);
        nrst = 1'b0;
        exp_q.delete();
        dbg_rsel = 5'd9;
        #1;
        checks++;
        if ({in_ready, wb_valid, dbg_rdata} !== {1'b1, 1'b0, 32'd0})
            $display("FAIL abort_wb: got rdy=%b v=%b x9=%h, required 1 0 0", in_ready, wb_valid, dbg_rdata);
        else
            passed++;
        @(negedge clk);
        nrst = 1'b1;
`ifdef EXEC_MD_EN
        issue(0, 0, 9, ALU_NOR, 1'b0, 0, 32'hFFFF_FFFF, 1'b0);
        issue(9, 9, 9, ALU_ADD, 1'b1, 0, 32'd1, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0)
            $display("FAIL abort_busy: got in_ready=%b, required 0", in_ready);
        else
            passed++;
        #2;
        nrst = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({in_ready, wb_valid, dbg_rdata} !== {1'b1, 1'b0, 32'd0})
            $display("FAIL abort_md: got rdy=%b v=%b x9=%h, required 1 0 0", in_ready, wb_valid, dbg_rdata);
        else
            passed++;
        @(negedge clk);
        nrst = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (dbg_rdata !== 32'd0)
            $display("FAIL abort_md_reg: got x9=%h, required 0", dbg_rdata);
        else
            passed++;
`endif
    endtask

    task automatic test_preload();
        issue(0, 0, 10, ALU_NOR, 1'b0, 0, 32'hFFFF_FFFF, 1'b0);
        issue(0, 10, 1, ALU_SUB, 1'b0, 0, 32'd1, 1'b0);
        issue(1, 1, 2, ALU_ADD, 1'b0, 0, 32'd2, 1'b0);
        issue(2, 2, 3, ALU_ADD, 1'b0, 0, 32'd4, 1'b0);
        issue(3, 2, 2, ALU_ADD, 1'b0, 0, 32'd6, 1'b0);
        issue(2, 1, 2, ALU_ADD, 1'b0, 0, 32'd7, 1'b0);
        issue(3, 1, 1, ALU_ADD, 1'b0, 0, 32'd5, 1'b0);
        drain();
        dbg_rsel = 5'd1;
        #1;
        checks++;
        if (dbg_rdata !== 32'd5) $display("FAIL preload_x1: got %h, required 5", dbg_rdata);
        else passed++;
        dbg_rsel = 5'd2;
        #1;
        checks++;
        if (dbg_rdata !== 32'd7) $display("FAIL preload_x2: got %h, required 7", dbg_rdata);
        else passed++;
    endtask

    task automatic test_add();
        wb_cyc_q.delete();
        issue(1, 2, 3, ALU_ADD, 1'b0, 0, 32'd12, 1'b0);
        dbg_rsel = 5'd3;
        #1;
        checks++;
        if (dbg_rdata !== 32'd4) $display("FAIL dbg_no_forward: got %h, required 4", dbg_rdata);
        else passed++;
        drain();
        checks++;
        if (wb_cyc_q.size() != 1 || wb_cyc_q[0] - last_acc + 1 != 1)
            $display("FAIL add_latency: got %0d results, latency %0d, required 1 result latency 1",
                     wb_cyc_q.size(), wb_cyc_q.size() > 0 ? wb_cyc_q[0] - last_acc + 1 : -1);
        else
            passed++;
        #1;
        checks++;
        if (dbg_rdata !== 32'd12) $display("FAIL add_x3: got %h, required 12", dbg_rdata);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok = 1'b1;
        wb_cyc_q.delete();
        issue(3, 3, 4, ALU_ADD, 1'b0, 0, 32'd24, 1'b0);
        issue(4, 1, 5, ALU_ADD, 1'b0, 0, 32'd29, 1'b0);
        issue(1, 5, 6, ALU_SUB, 1'b0, 0, 32'hFFFF_FFE8, 1'b0);
        issue(5, 1, 7, ALU_SLL, 1'b0, 0, 32'd928, 1'b0);
        issue(6, 1, 8, ALU_SRA, 1'b0, 0, 32'hFFFF_FFFF, 1'b0);
        issue(6, 1, 9, ALU_SLT, 1'b0, 0, 32'd1, 1'b0);
        drain();
        for (int i = 0; i < wb_cyc_q.size(); i++)
            if (wb_cyc_q[i] != wb_cyc_q[0] + i) ok = 1'b0;
        checks++;
        if (wb_cyc_q.size() != 6 || !ok)
            $display("FAIL b2b_throughput: got %0d results contiguous=%b, required 6 contiguous", wb_cyc_q.size(), ok);
        else
            passed++;
    endtask

    task automatic test_x0();
        issue(1, 2, 0, ALU_ADD, 1'b0, 0, 32'd12, 1'b0);
        issue(0, 1, 8, ALU_ADD, 1'b0, 0, 32'd5, 1'b0);
        drain();
        dbg_rsel = 5'd0;
        #1;
        checks++;
        if (dbg_rdata !== 32'd0) $display("FAIL x0_write: got %h, required 0", dbg_rdata);
        else passed++;
        dbg_rsel = 5'd8;
        #1;
        checks++;
        if (dbg_rdata !== 32'd5) $display("FAIL x0_forward: got %h, required 5", dbg_rdata);
        else passed++;
    endtask

`ifdef EXEC_MD_EN
    task automatic test_md();
        int acc;
        wb_cyc_q.delete();
        issue(1, 2, 5, ALU_ADD, 1'b1, 0, 32'd35, 1'b0);
        acc = last_acc;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) $display("FAIL md_busy_ready: got %b, required 0", in_ready);
        else passed++;
        rs1 = 5'd1; rs2 = 5'd1; rd = 5'd13; op = ALU_ADD; is_md = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        checks++;
        if (wb_cyc_q.size() != 1 || wb_cyc_q[0] - acc + 1 != 33)
            $display("FAIL mul_latency: got %0d results, latency %0d, required 1 result latency 33",
                     wb_cyc_q.size(), wb_cyc_q.size() > 0 ? wb_cyc_q[0] - acc + 1 : -1);
        else
            passed++;
        issue(0, 2, 12, ALU_SUB, 1'b0, 0, 32'hFFFF_FFF9, 1'b0);
        issue(10, 10, 13, ALU_ADD, 1'b0, 0, 32'hFFFF_FFFE, 1'b0);
        issue(0, 13, 13, ALU_SUB, 1'b0, 0, 32'd2, 1'b0);
        issue(10, 10, 14, ALU_SLL, 1'b0, 0, 32'h8000_0000, 1'b0);
        issue(10, 10, 15, ALU_ADD, 1'b1, 1, 32'd0, 1'b0);
        issue(10, 10, 15, ALU_ADD, 1'b1, 3, 32'hFFFF_FFFE, 1'b0);
        issue(10, 10, 15, ALU_ADD, 1'b1, 2, 32'hFFFF_FFFF, 1'b0);
        issue(12, 13, 15, ALU_ADD, 1'b1, 0, 32'hFFFF_FFF2, 1'b0);
        issue(12, 13, 15, ALU_ADD, 1'b1, 4, 32'hFFFF_FFFD, 1'b0);
        issue(12, 13, 15, ALU_ADD, 1'b1, 6, 32'hFFFF_FFFF, 1'b0);
        issue(12, 13, 15, ALU_ADD, 1'b1, 5, 32'h7FFF_FFFC, 1'b0);
        issue(12, 13, 15, ALU_ADD, 1'b1, 7, 32'd1, 1'b0);
        issue(14, 10, 15, ALU_ADD, 1'b1, 4, 32'h8000_0000, 1'b0);
        issue(14, 10, 15, ALU_ADD, 1'b1, 6, 32'd0, 1'b0);
        issue(1, 0, 15, ALU_ADD, 1'b1, 7, 32'd5, 1'b0);
        wb_cyc_q.delete();
        issue(1, 0, 16, ALU_ADD, 1'b1, 5, 32'hFFFF_FFFF, 1'b0);
        acc = last_acc;
        drain();
        checks++;
        if (wb_cyc_q.size() != 1 || wb_cyc_q[0] - acc + 1 != 1)
            $display("FAIL div0_latency: got %0d results, latency %0d, required 1 result latency 1",
                     wb_cyc_q.size(), wb_cyc_q.size() > 0 ? wb_cyc_q[0] - acc + 1 : -1);
        else
            passed++;
        dbg_rsel = 5'd5;
        #1;
        checks++;
        if (dbg_rdata !== 32'd35) $display("FAIL mul_x5: got %h, required 35", dbg_rdata);
        else passed++;
    endtask
`else
    task automatic test_illegal();
        int acc;
        wb_cyc_q.delete();
        issue(1, 2, 5, ALU_ADD, 1'b1, 0, 32'd0, 1'b1);
        acc = last_acc;
        issue(5, 0, 11, ALU_ADD, 1'b0, 0, 32'd29, 1'b0);
        issue(1, 0, 12, ALU_ADD, 1'b1, 4, 32'd0, 1'b1);
        drain();
        checks++;
        if (wb_cyc_q.size() != 3 || wb_cyc_q[0] - acc + 1 != 1)
            $display("FAIL illegal_latency: got %0d results, latency %0d, required 3 results latency 1",
                     wb_cyc_q.size(), wb_cyc_q.size() > 0 ? wb_cyc_q[0] - acc + 1 : -1);
        else
            passed++;
        dbg_rsel = 5'd5;
        #1;
        checks++;
        if (dbg_rdata !== 32'd29) $display("FAIL illegal_x5: got %h, required 29", dbg_rdata);
        else passed++;
        dbg_rsel = 5'd12;
        #1;
        checks++;
        if (dbg_rdata !== 32'd0) $display("FAIL illegal_x12: got %h, required 0", dbg_rdata);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_abort();
        test_preload();
        test_add();
        test_back_to_back();
        test_x0();
`ifdef EXEC_MD_EN
        test_md();
`else
        test_illegal();
`endif
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
